// File: rtl/rename_pkg.sv
// Shared rename-stage definitions: register-file geometry and free-list state encoding.
package rename_pkg;

    localparam int unsigned NumPhysRegs  = 64;
    localparam int unsigned NumArchRegs  = 32;
    localparam int unsigned NumCkpt      = 4;
    localparam int unsigned PhysRegWidth = $clog2(NumPhysRegs);

    // Free-list controller states: loading the initial tag set, then normal operation.
    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } fl_state_e;

    // Number of set bits in a two-slot request/valid vector.
    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/phys_free_list_if.sv
// Allocate/release/checkpoint handshake between the rename stage and the free list.
interface phys_free_list_if #(
    parameter int unsigned TagW = rename_pkg::PhysRegWidth
);

    logic [1:0]      alloc_req_i;
    logic            alloc_gnt_o;
    logic [TagW-1:0] alloc_tag_0_o;
    logic [TagW-1:0] alloc_tag_1_o;
    logic [1:0]      rel_valid_i;
    logic [TagW-1:0] rel_tag_0_i;
    logic [TagW-1:0] rel_tag_1_i;
    logic            save_i;
    logic            restore_i;

    // Rename/commit side: issues requests and releases, receives tags.
    modport master (
        output alloc_req_i, rel_valid_i, rel_tag_0_i, rel_tag_1_i, save_i, restore_i,
        input  alloc_gnt_o, alloc_tag_0_o, alloc_tag_1_o
    );

    // Free-list side.
    modport slave (
        input  alloc_req_i, rel_valid_i, rel_tag_0_i, rel_tag_1_i, save_i, restore_i,
        output alloc_gnt_o, alloc_tag_0_o, alloc_tag_1_o
    );

endinterface

// File: rtl/ckpt_stack.sv
// Checkpoint LIFO holding saved free-list head pointers; pop wins over push.
module ckpt_stack #(
    parameter int unsigned Depth = 4,
    parameter int unsigned DataW = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic [DataW-1:0] push_data,
    output logic [DataW-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int unsigned SpW  = $clog2(Depth + 1);
    localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [SpW-1:0]   sp_q;
    logic [DataW-1:0] mem_q [Depth];
    logic             do_push;
    logic             do_pop;

    // Status, top-of-stack view and legal push/pop qualification.
    always_comb begin
        empty   = (sp_q == '0);
        full    = (sp_q == SpW'(Depth));
        top     = '0;
        if (!empty) begin
            top = mem_q[IdxW'(sp_q - SpW'(1))];
        end
        do_pop  = pop && !empty;
        do_push = push && !pop && !full;
    end

    // Stack pointer and entry storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_q <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_pop) begin
            sp_q <= sp_q - SpW'(1);
        end else if (do_push) begin
            mem_q[IdxW'(sp_q)] <= push_data;
            sp_q               <= sp_q + SpW'(1);
        end
    end

endmodule

// File: rtl/phys_free_list.sv
// Physical register free list: circular tag FIFO with two-wide allocate/release
// and a checkpoint stack that rewinds the head on branch recovery.
module phys_free_list #(
    parameter int unsigned NumPhysRegs = rename_pkg::NumPhysRegs,
    parameter int unsigned NumArchRegs = rename_pkg::NumArchRegs,
    parameter int unsigned NumCkpt     = rename_pkg::NumCkpt,
    localparam int unsigned TagW       = $clog2(NumPhysRegs),
    localparam int unsigned Depth      = NumPhysRegs - NumArchRegs,
    localparam int unsigned PtrW       = $clog2(Depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    phys_free_list_if.slave bus,
    output logic            ready_o,
    output logic [PtrW-1:0] free_count_o,
    output logic            ckpt_full_o,
    output logic            ckpt_empty_o,
    output logic            err_o
);

    import rename_pkg::*;

    localparam int unsigned IdxW = PtrW - 1;

    fl_state_e       state_q, state_d;
    logic [IdxW-1:0] init_idx_q, init_idx_d;
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [PtrW-1:0] count_q, count_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;

    logic [TagW-1:0] tag_mem [Depth];

    logic            run;
    logic [PtrW-1:0] req_cnt;
    logic [PtrW-1:0] grant_cnt;
    logic            gnt;
    logic [PtrW-1:0] head_alloc;
    logic [PtrW-1:0] avail;
    logic            rel_ok_0, rel_ok_1;
    logic            acc_0, acc_1;
    logic            rel_ovf;
    logic [IdxW-1:0] head_idx;
    logic [IdxW-1:0] wr_idx_0, wr_idx_1;
    logic            ckpt_push, ckpt_pop;
    logic [PtrW-1:0] ckpt_top;
    logic            ckpt_full, ckpt_empty;

    ckpt_stack #(
        .Depth (NumCkpt),
        .DataW (PtrW)
    ) u_ckpt_stack (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (ckpt_push),
        .pop       (ckpt_pop),
        .push_data (head_alloc),
        .top       (ckpt_top),
        .full      (ckpt_full),
        .empty     (ckpt_empty)
    );

    // Grant and release acceptance; a release only lands if the list stays within Depth.
    always_comb begin
        run        = (state_q == StRun);
        req_cnt    = PtrW'(popcount2(bus.alloc_req_i));
        gnt        = run && (bus.alloc_req_i != 2'b00) && (count_q >= req_cnt) && !bus.restore_i;
        grant_cnt  = gnt ? req_cnt : '0;
        head_alloc = head_q + grant_cnt;
        avail      = count_q - grant_cnt;
        rel_ok_0   = run && bus.rel_valid_i[0] && (bus.rel_tag_0_i != '0);
        rel_ok_1   = run && bus.rel_valid_i[1] && (bus.rel_tag_1_i != '0);
        acc_0      = rel_ok_0 && (avail < PtrW'(Depth));
        acc_1      = rel_ok_1 && ((avail + PtrW'(acc_0)) < PtrW'(Depth));
        rel_ovf    = (rel_ok_0 && !acc_0) || (rel_ok_1 && !acc_1);
        head_idx   = head_q[IdxW-1:0];
        wr_idx_0   = tail_q[IdxW-1:0];
        wr_idx_1   = tail_q[IdxW-1:0] + IdxW'(acc_0);
    end

    // Tag outputs; slot 1 takes the second entry only when slot 0 also allocates.
    always_comb begin
        bus.alloc_gnt_o   = gnt;
        bus.alloc_tag_0_o = '0;
        bus.alloc_tag_1_o = '0;
        if (run) begin
            bus.alloc_tag_0_o = tag_mem[head_idx];
            bus.alloc_tag_1_o = bus.alloc_req_i[0] ? tag_mem[head_idx + IdxW'(1)]
                                                   : tag_mem[head_idx];
        end
    end

    // Next-state logic: init sweep, then pointer/count/checkpoint updates.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ready_d    = ready_q;
        err_d      = err_q;
        ckpt_push  = 1'b0;
        ckpt_pop   = 1'b0;

        case (state_q)
            StInit: begin
                init_idx_d = init_idx_q + IdxW'(1);
                if (init_idx_q == IdxW'(Depth - 1)) begin
                    state_d = StRun;
                    head_d  = '0;
                    tail_d  = PtrW'(Depth);
                    count_d = PtrW'(Depth);
                    ready_d = 1'b1;
                end
            end
            StRun: begin
                tail_d  = tail_q + PtrW'(acc_0) + PtrW'(acc_1);
                head_d  = head_alloc;
                count_d = avail + PtrW'(acc_0) + PtrW'(acc_1);
                if (rel_ovf) begin
                    err_d = 1'b1;
                end
                if (bus.restore_i) begin
                    // Restore outranks a simultaneous save; the save is dropped silently.
                    if (ckpt_empty) begin
                        err_d = 1'b1;
                    end else begin
                        ckpt_pop = 1'b1;
                        head_d   = ckpt_top;
                        count_d  = tail_d - ckpt_top;
                    end
                end else if (bus.save_i) begin
                    if (ckpt_full) begin
                        err_d = 1'b1;
                    end else begin
                        ckpt_push = 1'b1;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    // Control and pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StInit;
            init_idx_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    // Tag storage: reloaded by the init sweep, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (state_q == StInit) begin
            tag_mem[init_idx_q] <= TagW'(NumArchRegs) + TagW'(init_idx_q);
        end else begin
            if (acc_0) begin
                tag_mem[wr_idx_0] <= bus.rel_tag_0_i;
            end
            if (acc_1) begin
                tag_mem[wr_idx_1] <= bus.rel_tag_1_i;
            end
        end
    end

    assign ready_o      = ready_q;
    assign free_count_o = count_q;
    assign err_o        = err_q;
    assign ckpt_full_o  = ckpt_full;
    assign ckpt_empty_o = ckpt_empty;

endmodule

// File: tb/tb_phys_free_list.sv
// Directed bench for phys_free_list: a sequence-number model of the free list
// checked every cycle, plus literal expectations at the interesting points.
module tb_phys_free_list;

    import rename_pkg::*;

    localparam int unsigned TagW  = PhysRegWidth;
    localparam int unsigned Depth = NumPhysRegs - NumArchRegs;
    localparam int unsigned PtrW  = $clog2(Depth) + 1;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            ready_o;
    logic [PtrW-1:0] free_count_o;
    logic            ckpt_full_o;
    logic            ckpt_empty_o;
    logic            err_o;

    int n_checks = 0;
    int n_errors = 0;

    // Model: every tag ever made free, in order; allocation consumes by ordinal.
    int hist[$];
    int ckpt[$];
    int nalloc;
    int npush;
    int init_cnt;
    bit mready;
    bit merr;

    phys_free_list_if #(.TagW(TagW)) bus();

    phys_free_list dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .bus          (bus),
        .ready_o      (ready_o),
        .free_count_o (free_count_o),
        .ckpt_full_o  (ckpt_full_o),
        .ckpt_empty_o (ckpt_empty_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pc(input logic [1:0] r);
        return int'(r[0]) + int'(r[1]);
    endfunction

    function automatic bit m_gnt();
        return mready && (bus.alloc_req_i != 2'b00) && ((npush - nalloc) >= pc(bus.alloc_req_i))
               && !bus.restore_i;
    endfunction

    task automatic model_reset();
        hist.delete();
        ckpt.delete();
        nalloc   = 0;
        npush    = 0;
        init_cnt = 0;
        mready   = 1'b0;
        merr     = 1'b0;
    endtask

    task automatic model_step();
        int na;
        int avail;
        int tg[2];
        logic [1:0] v;
        if (!mready) begin
            init_cnt++;
            if (init_cnt == int'(Depth)) begin
                mready = 1'b1;
                for (int i = 0; i < int'(Depth); i++) hist.push_back(int'(NumArchRegs) + i);
                npush = int'(Depth);
            end
            return;
        end
        na    = nalloc + (m_gnt() ? pc(bus.alloc_req_i) : 0);
        avail = npush - na;
        v     = bus.rel_valid_i;
        tg[0] = int'(bus.rel_tag_0_i);
        tg[1] = int'(bus.rel_tag_1_i);
        for (int s = 0; s < 2; s++) begin
            if (v[s] && tg[s] != 0) begin
                if (avail < int'(Depth)) begin
                    hist.push_back(tg[s]);
                    npush++;
                    avail++;
                end else begin
                    merr = 1'b1;
                end
            end
        end
        if (bus.restore_i) begin
            if (ckpt.size() == 0) merr = 1'b1;
            else na = ckpt.pop_back();
        end else if (bus.save_i) begin
            if (ckpt.size() == int'(NumCkpt)) merr = 1'b1;
            else ckpt.push_back(na);
        end
        nalloc = na;
    endtask

    always @(posedge clk_i) begin
        if (rst_ni) model_step();
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_i) begin
        bit g;
        g = m_gnt();
        check("gnt", int'(bus.alloc_gnt_o), int'(g));
        if (g) begin
            check("tag0", int'(bus.alloc_tag_0_o), hist[nalloc]);
            check("tag1", int'(bus.alloc_tag_1_o), hist[nalloc + (bus.alloc_req_i[0] ? 1 : 0)]);
        end
        check("ready", int'(ready_o), int'(mready));
        check("free_count", int'(free_count_o), mready ? (npush - nalloc) : 0);
        check("ckpt_full", int'(ckpt_full_o), int'(ckpt.size() == int'(NumCkpt)));
        check("ckpt_empty", int'(ckpt_empty_o), int'(ckpt.size() == 0));
        check("err", int'(err_o), int'(merr));
    end

    task automatic set_in(input logic [1:0] req, input logic [1:0] rv, input int t0, input int t1,
                          input logic sv, input logic rs);
        bus.alloc_req_i = req;
        bus.rel_valid_i = rv;
        bus.rel_tag_0_i = TagW'(t0);
        bus.rel_tag_1_i = TagW'(t1);
        bus.save_i      = sv;
        bus.restore_i   = rs;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk_i);
    endtask

    // Asynchronous reset in mid-cycle, released just after the next edge.
    task automatic async_reset();
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        model_reset();
        #1;
        check("rst_ready", int'(ready_o), 0);
        check("rst_count", int'(free_count_o), 0);
        check("rst_empty", int'(ckpt_empty_o), 1);
        check("rst_full", int'(ckpt_full_o), 0);
        check("rst_err", int'(err_o), 0);
        check("rst_gnt", int'(bus.alloc_gnt_o), 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        model_reset();
        set_in(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        rst_ni = 1'b1;
        #1;
        rst_ni = 1'b0;
        at_neg();
        check("por_ready", int'(ready_o), 0);
        check("por_count", int'(free_count_o), 0);
        check("por_empty", int'(ckpt_empty_o), 1);
        check("por_gnt", int'(bus.alloc_gnt_o), 0);
        tick();
        rst_ni = 1'b1;

        // Init sweep ignores traffic; ready on the 33rd cycle.
        set_in(2'b11, 2'b11, 5, 6, 1'b1, 1'b1);
        repeat (31) tick();
        at_neg();
        check("init_ready_lo", int'(ready_o), 0);
        set_in(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        tick();
        at_neg();
        check("init_ready_hi", int'(ready_o), 1);
        check("init_count", int'(free_count_o), 32);
        check("first_tag0", int'(bus.alloc_tag_0_o), 32);
        check("first_tag1", int'(bus.alloc_tag_1_o), 33);
        tick();

        // Slot-1-only request when the head holds tag 40.
        repeat (3) tick();
        set_in(2'b10, 2'b00, 0, 0, 1'b0, 1'b0);
        at_neg();
        check("s1_count", int'(free_count_o), 24);
        check("s1_tag1", int'(bus.alloc_tag_1_o), 40);
        tick();
        set_in(2'b01, 2'b00, 0, 0, 1'b0, 1'b0);
        at_neg();
        check("s1_after_count", int'(free_count_o), 23);
        check("s0_tag0", int'(bus.alloc_tag_0_o), 41);
        tick();

        // Drain to one entry; a double request must not partially grant.
        set_in(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        repeat (10) tick();
        set_in(2'b01, 2'b00, 0, 0, 1'b0, 1'b0);
        tick();
        set_in(2'b11, 2'b01, 5, 0, 1'b0, 1'b0);
        at_neg();
        check("drain_count", int'(free_count_o), 1);
        check("drain_gnt", int'(bus.alloc_gnt_o), 0);
        tick();
        set_in(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        at_neg();
        check("rel5_count", int'(free_count_o), 2);
        check("rel5_gnt", int'(bus.alloc_gnt_o), 1);
        check("rel5_tag0", int'(bus.alloc_tag_0_o), 63);
        check("rel5_tag1", int'(bus.alloc_tag_1_o), 5);
        tick();
        set_in(2'b01, 2'b00, 0, 0, 1'b0, 1'b0);
        at_neg();
        check("empty_gnt", int'(bus.alloc_gnt_o), 0);

        // Refill, bring head to ring entry 4, then checkpoint and rewind.
        for (int k = 0; k < 5; k++) begin
            set_in(2'b00, 2'b11, 10 + 2 * k, 11 + 2 * k, 1'b0, 1'b0);
            tick();
        end
        set_in(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        at_neg();
        check("refill_tag0", int'(bus.alloc_tag_0_o), 10);
        check("refill_tag1", int'(bus.alloc_tag_1_o), 11);
        tick();
        set_in(2'b01, 2'b00, 0, 0, 1'b0, 1'b0);
        tick();
        set_in(2'b00, 2'b00, 0, 0, 1'b1, 1'b0);
        tick();
        set_in(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        at_neg();
        check("save_count", int'(free_count_o), 7);
        check("save_empty", int'(ckpt_empty_o), 0);
        repeat (3) tick();
        set_in(2'b00, 2'b11, 20, 21, 1'b0, 1'b0);
        tick();
        set_in(2'b11, 2'b00, 0, 0, 1'b0, 1'b1);
        at_neg();
        check("restore_gnt", int'(bus.alloc_gnt_o), 0);
        check("pre_restore_count", int'(free_count_o), 3);
        tick();
        set_in(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        at_neg();
        check("restore_count", int'(free_count_o), 9);
        check("restore_empty", int'(ckpt_empty_o), 1);
        check("rewind_tag0", int'(bus.alloc_tag_0_o), 13);
        check("rewind_tag1", int'(bus.alloc_tag_1_o), 14);
        tick();

        // Tag 0 release is dropped; release into a full list is an error.
        set_in(2'b00, 2'b01, 0, 0, 1'b0, 1'b0);
        tick();
        set_in(2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
        at_neg();
        check("tag0_count", int'(free_count_o), 7);
        check("tag0_err", int'(err_o), 0);
        for (int k = 0; k < 12; k++) begin
            set_in(2'b00, 2'b11, 22 + 2 * k, 23 + 2 * k, 1'b0, 1'b0);
            tick();
        end
        set_in(2'b00, 2'b01, 46, 0, 1'b0, 1'b0);
        tick();
        set_in(2'b00, 2'b01, 7, 0, 1'b0, 1'b0);
        at_neg();
        check("full_count", int'(free_count_o), 32);
        tick();
        set_in(2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
        at_neg();
        check("ovf_err", int'(err_o), 1);
        check("ovf_count", int'(free_count_o), 32);

        // Three checkpoints outstanding, then reset mid-run.
        set_in(2'b00, 2'b00, 0, 0, 1'b1, 1'b0);
        repeat (3) tick();
        set_in(2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
        at_neg();
        check("three_empty", int'(ckpt_empty_o), 0);
        check("three_full", int'(ckpt_full_o), 0);
        async_reset();
        repeat (31) tick();
        at_neg();
        check("rerun_ready_lo", int'(ready_o), 0);
        tick();
        at_neg();
        check("rerun_ready_hi", int'(ready_o), 1);
        check("rerun_count", int'(free_count_o), 32);

        // Stack full, save+restore together, then a fifth save.
        set_in(2'b00, 2'b00, 0, 0, 1'b1, 1'b0);
        repeat (4) tick();
        set_in(2'b00, 2'b00, 0, 0, 1'b1, 1'b1);
        at_neg();
        check("four_full", int'(ckpt_full_o), 1);
        check("four_err", int'(err_o), 0);
        tick();
        set_in(2'b00, 2'b00, 0, 0, 1'b1, 1'b0);
        at_neg();
        check("both_full", int'(ckpt_full_o), 0);
        check("both_err", int'(err_o), 0);
        tick();
        at_neg();
        check("refull", int'(ckpt_full_o), 1);
        tick();
        set_in(2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
        at_neg();
        check("fifth_err", int'(err_o), 1);
        check("fifth_full", int'(ckpt_full_o), 1);

        // Reset partway through the init sweep restarts it from entry 0.
        async_reset();
        repeat (17) tick();
        at_neg();
        check("mid_init_ready", int'(ready_o), 0);
        async_reset();
        set_in(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        repeat (31) tick();
        at_neg();
        check("reinit_ready_lo", int'(ready_o), 0);
        tick();
        at_neg();
        check("reinit_ready_hi", int'(ready_o), 1);
        check("reinit_count", int'(free_count_o), 32);
        check("reinit_tag0", int'(bus.alloc_tag_0_o), 32);
        check("reinit_tag1", int'(bus.alloc_tag_1_o), 33);
        tick();
        set_in(2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
